// File: rtl/ext_cmd_sequencer.sv
// ext_cmd_sequencer: queues host read/write commands in a small FIFO and issues
// them one at a time on the system_top external access port using the
// level-strobe/ready handshake, returning exactly one response per command.
// Optional feature macro: EXT_SEQ_TIMEOUT_EN adds the ext_ready timeout counter
// and error code 2; without it WAIT holds until ext_ready indefinitely.
module ext_cmd_sequencer #(
   parameter int MESH_SIZE_X    = 2,
   parameter int MESH_SIZE_Y    = 2,
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       cpu_clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [7:0]                 cmd_node,
   input  logic [7:0]                 cmd_addr,
   input  logic [31:0]                cmd_wdata,
   output logic [$clog2(CMD_DEPTH):0] cmd_level,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_write,
   output logic [31:0]                rsp_rdata,
   output logic [1:0]                 rsp_error,
   output logic [7:0]                 ext_node_select,
   output logic [7:0]                 ext_addr,
   output logic                       ext_write_en,
   output logic                       ext_read_en,
   output logic [31:0]                ext_write_data,
   input  logic [31:0]                ext_read_data,
   input  logic                       ext_ready
);

   localparam int AW = $clog2(CMD_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(CMD_DEPTH);
   localparam logic [4:0] LIMIT_X = 5'(MESH_SIZE_X);
   localparam logic [4:0] LIMIT_Y = 5'(MESH_SIZE_Y);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t state, state_next;

   logic          fifo_write [CMD_DEPTH];
   logic [7:0]    fifo_node  [CMD_DEPTH];
   logic [7:0]    fifo_addr  [CMD_DEPTH];
   logic [31:0]   fifo_wdata [CMD_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_next;

   logic          push, pop;
   logic          head_write;
   logic [7:0]    head_node, head_addr;
   logic [31:0]   head_wdata;
   logic          node_ok;

   logic          issue, reject, done_ok, done_timeout, accept;
   logic          timed_out;

   assign push       = cmd_valid && cmd_ready;
   assign pop        = issue || reject;
   assign head_write = fifo_write[rd_ptr];
   assign head_node  = fifo_node[rd_ptr];
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_wdata = fifo_wdata[rd_ptr];
   assign node_ok    = ({1'b0, head_node[7:4]} < LIMIT_X) && ({1'b0, head_node[3:0]} < LIMIT_Y);

   // FIFO storage is written on every accepted push; no reset needed for the payload
   always_ff @(posedge cpu_clk) begin
      if (push) begin
         fifo_write[wr_ptr] <= cmd_write;
         fifo_node[wr_ptr]  <= cmd_node;
         fifo_addr[wr_ptr]  <= cmd_addr;
         fifo_wdata[wr_ptr] <= cmd_wdata;
      end
   end

   // Occupancy after this edge; a simultaneous push and pop leaves it unchanged
   always_comb begin
      level_next = cmd_level;
      if (push && !pop) begin
         level_next = cmd_level + 1'b1;
      end else if (pop && !push) begin
         level_next = cmd_level - 1'b1;
      end
   end

   // FIFO pointers, occupancy and the registered not-full flag
   always_ff @(posedge cpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_level <= '0;
         cmd_ready <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         cmd_level <= level_next;
         cmd_ready <= (level_next != FULL_LEVEL);
      end
   end

`ifdef EXT_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] wait_count;

   assign timed_out = (wait_count == TW'(TIMEOUT_CYCLES - 1));

   // Counts sampling edges spent in WAIT without ready; cleared on each issue
   always_ff @(posedge cpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_count <= '0;
      end else if (issue) begin
         wait_count <= '0;
      end else if ((state == WAIT) && !ext_ready) begin
         wait_count <= wait_count + 1'b1;
      end
   end
`else
   assign timed_out = 1'b0;
`endif

   // State register
   always_ff @(posedge cpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (cmd_level != '0) state_next = node_ok ? WAIT : RESP;
         WAIT: if (ext_ready || timed_out) state_next = RESP;
         RESP: if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Per-state action strobes that drive the registered outputs
   always_comb begin
      issue        = 1'b0;
      reject       = 1'b0;
      done_ok      = 1'b0;
      done_timeout = 1'b0;
      accept       = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_level != '0) begin
               issue  = node_ok;
               reject = !node_ok;
            end
         end
         WAIT: begin
            if (ext_ready) begin
               done_ok = 1'b1;
            end else if (timed_out) begin
               done_timeout = 1'b1;
            end
         end
         RESP: accept = rsp_ready;
         default: ;
      endcase
   end

   // Registered ext port and response outputs; the enables double as the op type in WAIT
   always_ff @(posedge cpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_node_select <= '0;
         ext_addr        <= '0;
         ext_write_data  <= '0;
         ext_write_en    <= 1'b0;
         ext_read_en     <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_write       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_error       <= '0;
      end else begin
         if (issue) begin
            ext_node_select <= head_node;
            ext_addr        <= head_addr;
            ext_write_data  <= head_wdata;
            ext_write_en    <= head_write;
            ext_read_en     <= !head_write;
         end
         if (reject) begin
            rsp_valid <= 1'b1;
            rsp_write <= head_write;
            rsp_rdata <= '0;
            rsp_error <= 2'd1;
         end
         if (done_ok) begin
            ext_write_en <= 1'b0;
            ext_read_en  <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= ext_write_en;
            rsp_rdata    <= ext_read_en ? ext_read_data : '0;
            rsp_error    <= 2'd0;
         end
         if (done_timeout) begin
            ext_write_en <= 1'b0;
            ext_read_en  <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= ext_write_en;
            rsp_rdata    <= '0;
            rsp_error    <= 2'd2;
         end
         if (accept) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ext_cmd_sequencer.sv
// tb_ext_cmd_sequencer: directed stimulus for ext_cmd_sequencer with a
// transaction-level model (command queue + one in-flight request) checked
// every cycle, plus hand-computed literal checks at key points.
module tb_ext_cmd_sequencer;

   localparam int MESH_X  = 2;
   localparam int MESH_Y  = 2;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
`ifdef EXT_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        cpu_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [7:0]  cmd_node = 8'h00;
   logic [7:0]  cmd_addr = 8'h00;
   logic [31:0] cmd_wdata = 32'h0;
   logic [2:0]  cmd_level;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_error;
   logic [7:0]  ext_node_select;
   logic [7:0]  ext_addr;
   logic        ext_write_en;
   logic        ext_read_en;
   logic [31:0] ext_write_data;
   logic [31:0] ext_read_data = 32'h0;
   logic        ext_ready = 1'b0;

   int compared = 0;
   int mismatched = 0;
   bit checking = 1'b0;
   int dut_rsp_count = 0;

   ext_cmd_sequencer #(
      .MESH_SIZE_X(MESH_X),
      .MESH_SIZE_Y(MESH_Y),
      .CMD_DEPTH(DEPTH),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .cpu_clk(cpu_clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_node(cmd_node),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .cmd_level(cmd_level),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error),
      .ext_node_select(ext_node_select),
      .ext_addr(ext_addr),
      .ext_write_en(ext_write_en),
      .ext_read_en(ext_read_en),
      .ext_write_data(ext_write_data),
      .ext_read_data(ext_read_data),
      .ext_ready(ext_ready)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 cpu_clk = ~cpu_clk;

   typedef struct {
      logic        wr;
      logic [7:0]  node;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } cmd_t;

   cmd_t        cmd_q[$];
   bit          m_busy = 1'b0;
   cmd_t        m_cur;
   int          m_waited = 0;
   bit          m_rsp_pending = 1'b0;
   logic        m_rsp_write = 1'b0;
   logic [31:0] m_rsp_rdata = 32'h0;
   logic [1:0]  m_rsp_error = 2'd0;
   logic [7:0]  m_node = 8'h00;
   logic [7:0]  m_addr = 8'h00;
   logic [31:0] m_wdata = 32'h0;
   int          rsp_count = 0;

   function automatic bit nodeInRange(input logic [7:0] n);
      return (int'(n[7:4]) < MESH_X) && (int'(n[3:0]) < MESH_Y);
   endfunction

   task automatic modelReset();
      cmd_q.delete();
      m_busy        = 1'b0;
      m_waited      = 0;
      m_rsp_pending = 1'b0;
      m_rsp_write   = 1'b0;
      m_rsp_rdata   = 32'h0;
      m_rsp_error   = 2'd0;
      m_node        = 8'h00;
      m_addr        = 8'h00;
      m_wdata       = 32'h0;
   endtask

   // One clock edge of the sequencer seen as: finish/deliver the current job, else start the next
   task automatic modelStep();
      int   pre_size;
      cmd_t c;
      pre_size = cmd_q.size();
      if (m_rsp_pending) begin
         if (rsp_ready) begin
            m_rsp_pending = 1'b0;
            rsp_count++;
         end
      end else if (m_busy) begin
         if (ext_ready) begin
            m_busy        = 1'b0;
            m_rsp_pending = 1'b1;
            m_rsp_write   = m_cur.wr;
            m_rsp_rdata   = m_cur.wr ? 32'h0 : ext_read_data;
            m_rsp_error   = 2'd0;
         end else begin
            m_waited++;
            if (TO_EN && m_waited == TIMEOUT) begin
               m_busy        = 1'b0;
               m_rsp_pending = 1'b1;
               m_rsp_write   = m_cur.wr;
               m_rsp_rdata   = 32'h0;
               m_rsp_error   = 2'd2;
            end
         end
      end else if (pre_size > 0) begin
         m_cur = cmd_q.pop_front();
         if (nodeInRange(m_cur.node)) begin
            m_busy   = 1'b1;
            m_waited = 0;
            m_node   = m_cur.node;
            m_addr   = m_cur.addr;
            m_wdata  = m_cur.wdata;
         end else begin
            m_rsp_pending = 1'b1;
            m_rsp_write   = m_cur.wr;
            m_rsp_rdata   = 32'h0;
            m_rsp_error   = 2'd1;
         end
      end
      if (cmd_valid && pre_size < DEPTH) begin
         c.wr    = cmd_write;
         c.node  = cmd_node;
         c.addr  = cmd_addr;
         c.wdata = cmd_wdata;
         cmd_q.push_back(c);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge cpu_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic wr, input logic [7:0] node, input logic [7:0] addr,
                                input logic [31:0] wdata);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_node  = node;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      tick(1);
      cmd_valid = 1'b0;
   endtask

   // Model advances on the same edges (and async reset) as the DUT
   always @(posedge cpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         modelReset();
      end else begin
         modelStep();
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge cpu_clk) begin
      if (checking) begin
         checkOutput("cmd_ready", 32'(cmd_ready), 32'(cmd_q.size() < DEPTH));
         checkOutput("cmd_level", 32'(cmd_level), 32'(cmd_q.size()));
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_rsp_pending));
         checkOutput("ext_write_en", 32'(ext_write_en), 32'(m_busy && m_cur.wr));
         checkOutput("ext_read_en", 32'(ext_read_en), 32'(m_busy && !m_cur.wr));
         checkOutput("ext_node_select", 32'(ext_node_select), 32'(m_node));
         checkOutput("ext_addr", 32'(ext_addr), 32'(m_addr));
         if (m_busy && m_cur.wr) begin
            checkOutput("ext_write_data", ext_write_data, m_wdata);
         end
         if (m_rsp_pending) begin
            checkOutput("rsp_write", 32'(rsp_write), 32'(m_rsp_write));
            checkOutput("rsp_rdata", rsp_rdata, m_rsp_rdata);
            checkOutput("rsp_error", 32'(rsp_error), 32'(m_rsp_error));
         end
         if (rsp_valid && rsp_ready) begin
            dut_rsp_count++;
         end
      end
   end

   // Directed test sequence
   initial begin
      int model_base;
      int dut_base;

      tick(3);
      checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("reset cmd_level", 32'(cmd_level), 32'd0);
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset ext_write_en", 32'(ext_write_en), 32'd0);
      checkOutput("reset ext_read_en", 32'(ext_read_en), 32'd0);
      checkOutput("reset ext_node_select", 32'(ext_node_select), 32'd0);
      rst_n = 1'b1;
      checking = 1'b1;
      tick(2);

      $display("[TB] write node {1,0} addr 0x06");
      applyStimulus(1'b1, 8'h10, 8'h06, 32'h0000_0001);
      tick(1);
      checkOutput("t1 write_en issued", 32'(ext_write_en), 32'd1);
      checkOutput("t1 node", 32'(ext_node_select), 32'h10);
      checkOutput("t1 addr", 32'(ext_addr), 32'h06);
      checkOutput("t1 wdata", ext_write_data, 32'h0000_0001);
      tick(2);
      checkOutput("t1 write_en holding", 32'(ext_write_en), 32'd1);
      ext_ready = 1'b1;
      ext_read_data = 32'hDEAD_BEEF;
      tick(1);
      ext_ready = 1'b0;
      checkOutput("t1 write_en dropped", 32'(ext_write_en), 32'd0);
      checkOutput("t1 rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t1 rsp_write", 32'(rsp_write), 32'd1);
      checkOutput("t1 rsp_error", 32'(rsp_error), 32'd0);
      checkOutput("t1 rsp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
      checkOutput("t1 rsp_valid cleared", 32'(rsp_valid), 32'd0);

      $display("[TB] read node {0,0} addr 0x03, minimum latency");
      applyStimulus(1'b0, 8'h00, 8'h03, 32'h0);
      ext_ready = 1'b1;
      ext_read_data = 32'h4120_0000;
      tick(1);
      checkOutput("t2 read_en issued", 32'(ext_read_en), 32'd1);
      checkOutput("t2 addr", 32'(ext_addr), 32'h03);
      tick(1);
      ext_ready = 1'b0;
      checkOutput("t2 read_en dropped", 32'(ext_read_en), 32'd0);
      checkOutput("t2 rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t2 rsp_rdata", rsp_rdata, 32'h4120_0000);
      checkOutput("t2 rsp_error", 32'(rsp_error), 32'd0);
      checkOutput("t2 rsp_write", 32'(rsp_write), 32'd0);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;

      $display("[TB] bad node {2,0}");
      applyStimulus(1'b0, 8'h20, 8'h04, 32'h0);
      tick(1);
      checkOutput("t4 rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t4 rsp_error", 32'(rsp_error), 32'd1);
      checkOutput("t4 rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("t4 read_en", 32'(ext_read_en), 32'd0);
      checkOutput("t4 node held", 32'(ext_node_select), 32'h00);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;

      $display("[TB] fill FIFO with ext stalled");
      model_base = rsp_count;
      dut_base = dut_rsp_count;
      applyStimulus(1'b1, 8'h11, 8'h01, 32'hA5A5_0001);
      applyStimulus(1'b0, 8'h01, 8'h02, 32'h0);
      applyStimulus(1'b1, 8'h10, 8'h03, 32'h0000_0C03);
      applyStimulus(1'b0, 8'h30, 8'h04, 32'h0);
      checkOutput("t3 level 3", 32'(cmd_level), 32'd3);
      checkOutput("t3 ready at 3", 32'(cmd_ready), 32'd1);
      applyStimulus(1'b0, 8'h11, 8'h05, 32'h0);
      checkOutput("t3 level 4", 32'(cmd_level), 32'd4);
      checkOutput("t3 ready at 4", 32'(cmd_ready), 32'd0);
      applyStimulus(1'b1, 8'h00, 8'h06, 32'h0000_FFFF);
      checkOutput("t3 refused level", 32'(cmd_level), 32'd4);
      checkOutput("t3 head stalled", 32'(ext_write_en), 32'd1);
      rsp_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         ext_ready = 1'b1;
         ext_read_data = 32'hB000_0000 + i;
         tick(1);
      end
      ext_ready = 1'b0;
      rsp_ready = 1'b0;
      checkOutput("t3 model responses", 32'(rsp_count - model_base), 32'd5);
      checkOutput("t3 dut responses", 32'(dut_rsp_count - dut_base), 32'd5);
      checkOutput("t3 drained level", 32'(cmd_level), 32'd0);

      $display("[TB] ext_ready held low");
      applyStimulus(1'b1, 8'h01, 8'h07, 32'h0000_0055);
      applyStimulus(1'b0, 8'h11, 8'h08, 32'h0);
      checkOutput("t5 write_en issued", 32'(ext_write_en), 32'd1);
`ifdef EXT_SEQ_TIMEOUT_EN
      tick(63);
      checkOutput("t5 write_en before timeout", 32'(ext_write_en), 32'd1);
      checkOutput("t5 no rsp before timeout", 32'(rsp_valid), 32'd0);
      tick(1);
      checkOutput("t5 write_en after timeout", 32'(ext_write_en), 32'd0);
      checkOutput("t5 rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t5 rsp_error", 32'(rsp_error), 32'd2);
      checkOutput("t5 rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("t5 rsp_write", 32'(rsp_write), 32'd1);
`else
      tick(99);
      checkOutput("t5 write_en still waiting", 32'(ext_write_en), 32'd1);
      checkOutput("t5 no rsp while waiting", 32'(rsp_valid), 32'd0);
      ext_ready = 1'b1;
      tick(1);
      ext_ready = 1'b0;
      checkOutput("t5 write_en dropped", 32'(ext_write_en), 32'd0);
      checkOutput("t5 rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t5 rsp_error", 32'(rsp_error), 32'd0);
`endif
      rsp_ready = 1'b1;
      tick(1);
      tick(1);
      checkOutput("t5 next read issued", 32'(ext_read_en), 32'd1);
      checkOutput("t5 next node", 32'(ext_node_select), 32'h11);
      ext_ready = 1'b1;
      ext_read_data = 32'h0BAD_F00D;
      tick(1);
      ext_ready = 1'b0;
      checkOutput("t5 next rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t5 next rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
      checkOutput("t5 next rsp_error", 32'(rsp_error), 32'd0);
      tick(1);
      rsp_ready = 1'b0;

      $display("[TB] reset while waiting with 2 queued");
      applyStimulus(1'b0, 8'h01, 8'h09, 32'h0);
      applyStimulus(1'b1, 8'h10, 8'h0A, 32'h0000_0077);
      applyStimulus(1'b0, 8'h11, 8'h0B, 32'h0);
      checkOutput("t6 read_en before reset", 32'(ext_read_en), 32'd1);
      checkOutput("t6 level before reset", 32'(cmd_level), 32'd2);
      rst_n = 1'b0;
      #1;
      checkOutput("t6 read_en async drop", 32'(ext_read_en), 32'd0);
      checkOutput("t6 level async clear", 32'(cmd_level), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      checkOutput("t6 level after reset", 32'(cmd_level), 32'd0);
      checkOutput("t6 no response", 32'(rsp_valid), 32'd0);
      checkOutput("t6 no enable", 32'(ext_read_en | ext_write_en), 32'd0);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ext_cmd_sequencer.md
# ext_cmd_sequencer

Host-side command sequencer that sits directly upstream of `system_top` and drives its external access port (`ext_node_select`, `ext_addr`, `ext_write_en`, `ext_read_en`, `ext_write_data`, `ext_read_data`, `ext_ready`). It queues host read/write commands in a small FIFO and issues them one at a time using the level-strobe/ready handshake. It returns exactly one response per command: read data, or an error for a bad node or a timeout.

## Interface
- `MESH_SIZE_X`, 2, mesh columns; used for node range check
- `MESH_SIZE_Y`, 2, mesh rows; used for node range check
- `CMD_DEPTH`, 4, command FIFO entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 64, maximum wait for `ext_ready`, counted in `cpu_clk` cycles
- `cpu_clk`  in  1  sole clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  host command valid
- `cmd_ready`  out  1  FIFO not full
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_node`  in  8  node select `{x[3:0], y[3:0]}`
- `cmd_addr`  in  8  register address within the node
- `cmd_wdata`  in  32  write data
- `cmd_level`  out  $clog2(CMD_DEPTH)+1  FIFO occupancy
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  host accepts response
- `rsp_write`  out  1  echo of `cmd_write`
- `rsp_rdata`  out  32  read data; 0 for writes and errors
- `rsp_error`  out  2  0 = ok, 1 = bad node, 2 = timeout
- `ext_node_select`  out  8  to `system_top`
- `ext_addr`  out  8  to `system_top`
- `ext_write_en`  out  1  to `system_top`
- `ext_read_en`  out  1  to `system_top`
- `ext_write_data`  out  32  to `system_top`
- `ext_read_data`  in  32  from `system_top`
- `ext_ready`  in  1  from `system_top`

## Operation
- FIFO push on `cmd_valid && cmd_ready`. If a push and a pop happen in the same cycle, `cmd_level` is unchanged. When the FIFO is full, `cmd_ready` is 0 and the command is not accepted. Pointers wrap modulo `CMD_DEPTH`.
- FSM states: IDLE, WAIT, RESP.
- IDLE, FIFO non-empty: pop the head entry.
  - Node out of range (x ≥ `MESH_SIZE_X` or y ≥ `MESH_SIZE_Y`): load response with error 1 and go to RESP. No ext access is made.
  - Otherwise: register the `ext_*` address/data outputs, set `ext_write_en` or `ext_read_en`, clear the timeout counter, and go to WAIT.
- WAIT, `ext_ready` = 1 on the sampling edge: deassert both enables, capture `ext_read_data` (reads only), set error 0, and go to RESP.
- WAIT, no ready: increment the counter. When the counter reaches `TIMEOUT_CYCLES`, deassert the enables, set error 2 with rdata 0, and go to RESP.
- RESP: `rsp_valid` = 1 and all `rsp_*` fields are held stable until `rsp_ready`. On acceptance, return to IDLE.
- `ext_node_select`, `ext_addr` and `ext_write_data` hold their last values while idle. The enables are high only in WAIT.
- Reset mid-transaction drops everything: the FIFO empties, the FSM goes to IDLE, and the enables fall immediately (asynchronously).

## Timing
- All outputs are registered.
- Reset values: `cmd_ready` = 1, `cmd_level` = 0, `rsp_valid` = 0, and all other outputs 0.
- Command pushed at edge N with FIFO empty and FSM in IDLE: the enable is high after edge N+1.
- `ext_ready` is sampled from edge N+2 onward. With ready held high, `rsp_valid` rises after edge N+2 (3-cycle minimum latency).
- Bad-node response: `rsp_valid` rises after edge N+1.
- Enables are low for at least one cycle between back-to-back transactions (RESP ≥1 cycle).
- Timeout: the enable stays high for exactly `TIMEOUT_CYCLES` sampling edges, then falls.
- Throughput: at most one transaction per 3 cycles.

## Configuration
- `EXT_SEQ_TIMEOUT_EN` defined: the timeout counter and error code 2 are implemented.
- Undefined: no counter. WAIT holds until `ext_ready`, indefinitely, and error code 2 is never produced.

## Test plan
- Write node {1,0}, addr 0x06, data 0x00000001; ready returned 3 cycles later → `ext_write_en` high for exactly the wait period; response write=1, error 0, rdata 0.
- Read node {0,0}, addr 0x03; ready with `ext_read_data` = 0x41200000 → `rsp_rdata` = 0x41200000, error 0, `ext_read_en` low the cycle after ready.
- Push 5 commands into a depth-4 FIFO with `rsp_ready` = 0 and ext stalled → `cmd_ready` falls when `cmd_level` = 4. Responses then come out in order, one per command.
- Command to node {2,0} with `MESH_SIZE_X` = 2 → no enable pulse; error 1 two cycles after the push.
- With `EXT_SEQ_TIMEOUT_EN` and `ext_ready` tied to 0 → enable high for 64 cycles, then error 2, rdata 0. The next queued command issues normally.
- Assert `rst_n` low while in WAIT with 2 commands queued → enables drop without waiting for a clock edge. After release, `cmd_level` = 0 and no response is produced.
